// File: rtl/viterbi_pkg.sv
// Shared constants and types for the K=3, rate-1/2 Viterbi frame controller.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int FRAME_LEN  = 15;
    localparam int COL_W      = 4;
    localparam int TB_TIMEOUT = 64;
    localparam int WD_W       = $clog2(TB_TIMEOUT);

    typedef logic [1:0] sym_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ACS,
        S_TB_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi trellis: accepts symbols, pulses init/ACS
// column strobes, launches traceback and guards it with a watchdog.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_in_valid,
    input  sym_t             i_in_sym,
    output logic             o_in_ready,
    output logic             o_init_en,
    output logic             o_acs_en,
    output logic [COL_W-1:0] o_col,
    output sym_t             o_sym,
    output logic             o_tb_start,
    input  logic             i_tb_done,
    output logic             o_frame_done,
    output logic             o_tb_timeout,
    output logic [7:0]       o_frame_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic [COL_W-1:0] r_sym_cnt;
    logic [WD_W-1:0]  r_wd_cnt;
    logic             r_init_en;
    logic             r_acs_en;
    logic [COL_W-1:0] r_col;
    sym_t             r_sym;
    logic             r_tb_start;
    logic             r_frame_done;
    logic             r_tb_timeout;
    logic [7:0]       r_frame_cnt;

    logic w_ready;
    logic w_accept;
    logic w_last;
    logic w_wd_exp;

    assign w_accept = i_in_valid && w_ready;
    assign w_last   = (r_sym_cnt == COL_W'(FRAME_LEN - 1));
    assign w_wd_exp = (r_wd_cnt == WD_W'(TB_TIMEOUT - 1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // Next-state decode; in_ready is purely a function of the current state.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_enable) w_next = S_INIT;
            end
            S_INIT: begin
                w_ready = 1'b1;
                if (w_accept && r_sym_cnt == COL_W'(K - 2)) w_next = S_ACS;
            end
            S_ACS: begin
                w_ready = 1'b1;
                if (w_accept && w_last) w_next = S_TB_WAIT;
            end
            S_TB_WAIT: begin
                // tb_done beats a simultaneous watchdog expiry.
                if (i_tb_done)     w_next = S_DONE;
                else if (w_wd_exp) w_next = S_IDLE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Column strobes, symbol capture, watchdog and frame bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sym_cnt    <= '0;
            r_wd_cnt     <= '0;
            r_init_en    <= 1'b0;
            r_acs_en     <= 1'b0;
            r_col        <= '0;
            r_sym        <= '0;
            r_tb_start   <= 1'b0;
            r_frame_done <= 1'b0;
            r_tb_timeout <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_init_en    <= 1'b0;
            r_acs_en     <= 1'b0;
            r_tb_start   <= 1'b0;
            r_frame_done <= 1'b0;

            if (r_state == S_IDLE && i_enable) r_sym_cnt <= '0;

            if (w_accept) begin
                r_col <= r_sym_cnt;
                r_sym <= i_in_sym;
                if (r_sym_cnt < COL_W'(K - 1)) r_init_en <= 1'b1;
                else                           r_acs_en  <= 1'b1;
                // The counter parks on the last column so col stays in range.
                if (w_last) begin
                    r_tb_start <= 1'b1;
                    r_wd_cnt   <= '0;
                end else begin
                    r_sym_cnt  <= r_sym_cnt + 1'b1;
                end
            end

            if (r_state == S_TB_WAIT) begin
                if (i_tb_done) begin
                    r_frame_done <= 1'b1;
                    r_frame_cnt  <= r_frame_cnt + 8'd1;
                end else if (w_wd_exp) begin
                    r_tb_timeout <= 1'b1;
                end else begin
                    r_wd_cnt     <= r_wd_cnt + 1'b1;
                end
            end
        end
    end

    assign o_in_ready   = w_ready;
    assign o_init_en    = r_init_en;
    assign o_acs_en     = r_acs_en;
    assign o_col        = r_col;
    assign o_sym        = r_sym;
    assign o_tb_start   = r_tb_start;
    assign o_frame_done = r_frame_done;
    assign o_tb_timeout = r_tb_timeout;
    assign o_frame_cnt  = r_frame_cnt;

endmodule
